// File: rtl/hpsdr_cdc_pkg.sv
// Shared CDC definitions: handshake FSM state encoding
// and the minimum synchroniser depth.
package hpsdr_cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } cdc_state_e;

  localparam int CDC_MIN_DEPTH = 2;

endpackage

// File: rtl/sync.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Ports: clock/reset (async, active-high), d_i async input, q_o synchronised output.
module sync
  import hpsdr_cdc_pkg::*;
#(
  parameter int DEPTH = CDC_MIN_DEPTH
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  // Never fewer than the minimum number of stages.
  localparam int D =
    (DEPTH < CDC_MIN_DEPTH) ? CDC_MIN_DEPTH : DEPTH;

  logic [D-1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[D-2:0], d_i};
    end
  end

  assign q_o = sync_q[D-1];

endmodule

// File: rtl/cdc_word_sender.sv
// Source end of a two-phase toggle CDC word handshake with one-word pending buffer.
// Ports: clock/reset, in_valid/in_data/in_ready in, ack_toggle from dest, req_toggle/xfer_data out, done/busy/timeout status.
module cdc_word_sender
  import hpsdr_cdc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ACK_DEPTH = 2,
  parameter int TIMEOUT   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             ack_toggle,
  output logic             req_toggle,
  output logic [WIDTH-1:0] xfer_data,
  output logic             done,
  output logic             busy,
  output logic             timeout
);

  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT > 0);

  cdc_state_e       state_q, state_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] xfer_q, xfer_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic ack_sync;
  logic accept;
  logic complete;

  sync #(
    .DEPTH (ACK_DEPTH)
  ) u_ack_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (ack_toggle),
    .q_o   (ack_sync)
  );

  assign in_ready = !pend_valid_q;
  assign accept   = in_valid && in_ready;
  // Ack has caught up with the outstanding request.
  assign complete = (state_q == WAIT_ACK) &&
                    (ack_sync == req_q);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    xfer_d       = xfer_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    done_d       = 1'b0;
    cnt_d        = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          xfer_d  = in_data;
          req_d   = ~req_q;
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (complete) begin
          done_d = 1'b1;
          if (pend_valid_q) begin
            xfer_d       = pend_q;
            req_d        = ~req_q;
            pend_valid_d = 1'b0;
            cnt_d        = '0;
          end else if (in_valid) begin
            // Direct relaunch: no idle bubble between words.
            xfer_d = in_data;
            req_d  = ~req_q;
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (accept) begin
            pend_d       = in_data;
            pend_valid_d = 1'b1;
          end
          if (cnt_q != TO_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    timeout_d = timeout_q ||
                (TO_EN && state_d == WAIT_ACK &&
                 cnt_d == TO_MAX);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      xfer_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      xfer_q       <= xfer_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_toggle = req_q;
  assign xfer_data  = xfer_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q == WAIT_ACK) ||
                      pend_valid_q;

endmodule
